// File: rtl/scan_pkg.sv
// Shared scan-path types and constants for the DFT load/dump controllers.
package scan_pkg;

   localparam int SCAN_WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ACK       = 3'd1,
      WAIT_WORD = 3'd2,
      SHIFT     = 3'd3,
      CAPTURE   = 3'd4,
      COMMIT    = 3'd5
   } scan_load_state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, LSB-first right-shift register feeding the scan chain.
import scan_pkg::*;

module scan_shift_reg #(
   parameter int W = SCAN_WORD_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         sout
);

   logic [W-1:0] q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift) begin
         q <= {1'b0, q[W-1:1]};
      end
   end

   assign sout = q[0];

endmodule

// File: rtl/scan_load_ctrl.sv
// Scan-in controller: host words -> serial chain, then commit/ack.
// SCAN_LOAD_CAPTURE_EN adds one functional capture cycle before commit.
import scan_pkg::*;

module scan_load_ctrl #(
   parameter int WORD_W = SCAN_WORD_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              val_op,
   input  logic [CNT_W-1:0]  chain_len,
   output logic              op_ack,
   input  logic [WORD_W-1:0] din,
   input  logic              din_val,
   output logic              din_rdy,
   output logic              sc_sin,
   output logic              sc_sen,
   output logic              sc_ce,
   output logic              op_commit,
   input  logic              commit_ack
);

`ifdef SCAN_LOAD_CAPTURE_EN
   localparam scan_load_state_t FIN = CAPTURE;
`else
   localparam scan_load_state_t FIN = COMMIT;
`endif

   localparam logic [CNT_W-1:0] WORD_N = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   scan_load_state_t state;
   scan_load_state_t nxt;

   logic [CNT_W-1:0] bits_left;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] word_bits;
   logic             load;
   logic             shift;

   assign load      = (state == WAIT_WORD) && din_val;
   assign shift     = (state == SHIFT);
   assign word_bits = (bits_left < WORD_N) ? bits_left : WORD_N;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:      if (val_op) nxt = ACK;
         ACK:       nxt = (bits_left != '0) ? WAIT_WORD : FIN;
         WAIT_WORD: if (din_val) nxt = SHIFT;
         SHIFT: begin
            if (bits_left == ONE)     nxt = FIN;
            else if (word_cnt == ONE) nxt = WAIT_WORD;
         end
         CAPTURE:   nxt = COMMIT;
         COMMIT:    if (commit_ack) nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         bits_left <= '0;
         word_cnt  <= '0;
         op_ack    <= 1'b0;
         din_rdy   <= 1'b0;
         sc_sen    <= 1'b0;
         sc_ce     <= 1'b0;
         op_commit <= 1'b0;
      end else begin
         state     <= nxt;
         op_ack    <= (nxt == ACK);
         din_rdy   <= (nxt == WAIT_WORD);
         sc_sen    <= (nxt == SHIFT);
         sc_ce     <= (nxt == SHIFT) || (nxt == CAPTURE);
         op_commit <= (nxt == COMMIT);
         if (state == IDLE && val_op) begin
            bits_left <= chain_len;
         end
         if (load) begin
            word_cnt <= word_bits;
         end
         if (shift) begin
            if (bits_left != '0) bits_left <= bits_left - ONE;
            if (word_cnt != '0)  word_cnt  <= word_cnt - ONE;
         end
      end
   end

   scan_shift_reg #(
      .W(WORD_W)
   ) u_shreg (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .shift(shift),
      .d    (din),
      .sout (sc_sin)
   );

endmodule

// File: tb/tb_scan_load_ctrl.sv
// Directed bench for scan_load_ctrl (default build, no capture cycle).
module tb_scan_load_ctrl;

   logic        clk;
   logic        reset;
   logic        val_op;
   logic [31:0] chain_len;
   logic        op_ack;
   logic [31:0] din;
   logic        din_val;
   logic        din_rdy;
   logic        sc_sin;
   logic        sc_sen;
   logic        sc_ce;
   logic        op_commit;
   logic        commit_ack;

   logic [31:0] w [3];
   int n_chk;
   int n_fail;

   logic [63:0] bits;
   int n_sen, t_com, n_wd, n_rdy, bad;

   scan_load_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .val_op    (val_op),
      .chain_len (chain_len),
      .op_ack    (op_ack),
      .din       (din),
      .din_val   (din_val),
      .din_rdy   (din_rdy),
      .sc_sin    (sc_sin),
      .sc_sen    (sc_sen),
      .sc_ce     (sc_ce),
      .op_commit (op_commit),
      .commit_ack(commit_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_outs"},
          {58'd0, op_ack, din_rdy, sc_sin, sc_sen, sc_ce, op_commit},
          64'd0);
   endtask

   // One complete load; returns the observed stream and timing.
   task automatic run_load(input logic [31:0] len, input int stall,
                           input bit perturb,
                           output logic [63:0] sbits, output int ns,
                           output int tc, output int nw, output int nr,
                           output int nbad);
      int  widx;
      int  stalled;
      bit  hs;
      sbits = '0; ns = 0; tc = -1; nw = 0; nr = 0; nbad = 0;
      widx = 0; stalled = 0;
      chain_len = len; din = w[0]; din_val = 1'b1; val_op = 1'b1;
      tick();
      val_op = 1'b0;
      chk("op_ack", {63'd0, op_ack}, 64'd1);
      for (int cyc = 1; cyc <= 300; cyc++) begin
         if (op_commit) begin
            tc = cyc;
            break;
         end
         if (sc_sen) begin
            if (ns < 64) sbits[ns] = sc_sin;
            ns++;
         end
         if (sc_ce !== sc_sen) nbad++;
         if (cyc > 1 && op_ack) nbad++;
         if (din_rdy) nr++;
         if (din_rdy && stalled < stall) begin
            din_val = 1'b0;
            stalled++;
         end else begin
            din_val = 1'b1;
         end
         if (perturb) begin
            val_op     = (cyc == 10);
            commit_ack = (cyc == 20);
         end
         hs = din_rdy && din_val;
         tick();
         if (hs) begin
            nw++;
            if (widx < 2) widx++;
            din = w[widx];
         end
      end
      val_op = 1'b0;
      commit_ack = 1'b0;
      din_val = 1'b0;
      tick();
      chk("commit_hold", {63'd0, op_commit}, 64'd1);
      commit_ack = 1'b1;
      tick();
      commit_ack = 1'b0;
      chk("commit_drop", {63'd0, op_commit}, 64'd0);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      reset = 1'b0; val_op = 1'b0; chain_len = '0; din = '0;
      din_val = 1'b0; commit_ack = 1'b0;
      w[0] = 32'hDEADBEEF; w[1] = 32'h12345678; w[2] = 32'h0;
      tick();
      chk_zero("reset");
      tick();
      reset = 1'b1;
      tick();
      chk_zero("idle");

      // 64 bits, two full words
      run_load(64, 0, 0, bits, n_sen, t_com, n_wd, n_rdy, bad);
      chk("t64_bits", bits, 64'h12345678DEADBEEF);
      chk("t64_sen", 64'(n_sen), 64'd64);
      chk("t64_commit", 64'(t_com), 64'd68);
      chk("t64_words", 64'(n_wd), 64'd2);
      chk("t64_bad", 64'(bad), 64'd0);

      // 40 bits: partial second word
      w[0] = 32'hFFFFFFFF; w[1] = 32'h000000A5;
      run_load(40, 0, 0, bits, n_sen, t_com, n_wd, n_rdy, bad);
      chk("t40_bits", bits, 64'h000000A5FFFFFFFF);
      chk("t40_sen", 64'(n_sen), 64'd40);
      chk("t40_commit", 64'(t_com), 64'd44);
      chk("t40_rdy", 64'(n_rdy), 64'd2);
      chk("t40_bad", 64'(bad), 64'd0);

      // zero length
      run_load(0, 0, 0, bits, n_sen, t_com, n_wd, n_rdy, bad);
      chk("t0_commit", 64'(t_com), 64'd2);
      chk("t0_sen", 64'(n_sen), 64'd0);
      chk("t0_rdy", 64'(n_rdy), 64'd0);
      chk("t0_bad", 64'(bad), 64'd0);

      // host stall of 5 cycles
      w[0] = 32'hDEADBEEF; w[1] = 32'h12345678;
      run_load(64, 5, 0, bits, n_sen, t_com, n_wd, n_rdy, bad);
      chk("stall_bits", bits, 64'h12345678DEADBEEF);
      chk("stall_commit", 64'(t_com), 64'd73);
      chk("stall_rdy", 64'(n_rdy), 64'd7);
      chk("stall_bad", 64'(bad), 64'd0);

      // stray val_op / commit_ack
      run_load(64, 0, 1, bits, n_sen, t_com, n_wd, n_rdy, bad);
      chk("pert_bits", bits, 64'h12345678DEADBEEF);
      chk("pert_commit", 64'(t_com), 64'd68);
      chk("pert_bad", 64'(bad), 64'd0);
      tick();
      chk("pert_idle", {62'd0, op_ack, op_commit}, 64'd0);

      // reset during the 10th shift cycle
      chain_len = 64; din = w[0]; din_val = 1'b1; val_op = 1'b1;
      tick();
      val_op = 1'b0;
      n_sen = 0;
      for (int i = 0; i < 40; i++) begin
         if (sc_sen) n_sen++;
         if (n_sen == 10) break;
         tick();
      end
      chk("rst_reach", 64'(n_sen), 64'd10);
      reset = 1'b0;
      #1;
      chk_zero("mid_reset");
      din_val = 1'b0;
      tick();
      chk_zero("held_reset");
      reset = 1'b1;
      tick();
      chk_zero("post_reset");
      run_load(64, 0, 0, bits, n_sen, t_com, n_wd, n_rdy, bad);
      chk("rerun_bits", bits, 64'h12345678DEADBEEF);
      chk("rerun_commit", 64'(t_com), 64'd68);
      chk("rerun_bad", 64'(bad), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
